// File: rtl/muldiv_unit_if.sv
// Handshake and result bundle between the control unit and the multiply/divide unit.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, div_zero, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit. Operands are reduced to magnitudes
// at start, iterated for WIDTH cycles in a shared 2*WIDTH accumulator, and
// sign-corrected into the hi/lo holding registers in FIX.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_unit_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_lo_q, neg_lo_d;   // product / quotient negative
  logic                 neg_hi_q, neg_hi_d;   // remainder negative (dividend sign)
  logic                 dz_q, dz_d;
  logic [WIDTH-1:0]     opb_q, opb_d;         // |multiplicand| or |divisor|
  logic [2*WIDTH-1:0]   acc_q, acc_d;         // {product hi, multiplier} or {rem, quo}
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;

  logic                 sgn, sa, sb;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH:0]       msum;
  logic [WIDTH:0]       rshift;
  logic [WIDTH+1:0]     rdiff;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  // Datapath step and next-state logic for the IDLE/RUN/FIX/DONE sequence.
  always_comb begin
    sgn   = ~bus.op[0];
    sa    = sgn & bus.a[WIDTH-1];
    sb    = sgn & bus.b[WIDTH-1];
    abs_a = sa ? -bus.a : bus.a;
    abs_b = sb ? -bus.b : bus.b;

    // Shift-add: conditionally add the multiplicand into the upper half, then shift right.
    msum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : {WIDTH{1'b0}})};
    // Restoring division: shift the next dividend bit into the remainder and trial-subtract.
    rshift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rdiff  = {1'b0, rshift} - {2'b00, opb_q};

    prod_fix = neg_lo_q ? -acc_q : acc_q;
    quo_fix  = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d     = dz_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      IDLE: if (bus.start) begin
        is_div_d = bus.op[1];
        neg_lo_d = sa ^ sb;
        neg_hi_d = sa;
        opb_d    = abs_b;
        acc_d    = {{WIDTH{1'b0}}, abs_a};
        cnt_d    = '0;
        if (bus.op[1] && (bus.b == '0)) begin
          dz_d    = 1'b1;
          state_d = DONE;
        end else begin
          dz_d    = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (is_div_q) begin
          if (!rdiff[WIDTH+1]) acc_d = {rdiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else                 acc_d = {rshift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {msum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
      end
      FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and holding registers; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      opb_q    <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dz_q     <= dz_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.div_zero = (state_q == DONE) & dz_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a 32-bit and an 8-bit instance share
// clock and reset; results are compared to plain-arithmetic expectations.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  muldiv_unit_if #(.WIDTH(32)) if32 ();
  muldiv_unit_if #(.WIDTH(8))  if8 ();

  muldiv_unit #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(if32.slave));
  muldiv_unit #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(if8.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic rd_busy(input bit s);
    return s ? if8.busy : if32.busy;
  endfunction
  function automatic logic rd_done(input bit s);
    return s ? if8.done : if32.done;
  endfunction
  function automatic logic rd_dz(input bit s);
    return s ? if8.div_zero : if32.div_zero;
  endfunction
  function automatic logic [31:0] rd_hi(input bit s);
    return s ? {24'b0, if8.hi} : if32.hi;
  endfunction
  function automatic logic [31:0] rd_lo(input bit s);
    return s ? {24'b0, if8.lo} : if32.lo;
  endfunction

  // Reference: exact integer arithmetic on 64-bit values, truncated to w bits.
  function automatic void model(input int w, input logic [1:0] op, input logic [31:0] a, b,
                                input logic [31:0] phi, plo,
                                output logic [31:0] ehi, elo, output bit edz);
    longint sa, sb, q, r;
    logic [63:0] p, m;
    m   = (64'd1 << w) - 64'd1;
    sa  = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb  = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
    edz = 1'b0;
    ehi = phi;
    elo = plo;
    case (op)
      2'b00: begin p = 64'(sa * sb); ehi = 32'((p >> w) & m); elo = 32'(p & m); end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; ehi = 32'((p >> w) & m); elo = 32'(p & m); end
      2'b10: if (b == 0) edz = 1'b1;
             else begin q = sa / sb; r = sa % sb; elo = 32'(64'(q) & m); ehi = 32'(64'(r) & m); end
      default: if (b == 0) edz = 1'b1;
               else begin elo = a / b; ehi = a % b; end
    endcase
  endfunction

  // Issue one operation and follow it to done. lat counts edges from the
  // sampling edge (inclusive) to the edge after which done is seen.
  task automatic do_op(input bit s, input logic [1:0] op, input logic [31:0] a, b,
                       output logic [31:0] hi, output logic [31:0] lo, output int lat,
                       output bit dz, output int bcnt, output bit ok, output bit idle_after,
                       output int scyc);
    @(negedge clk);
    if (s) begin if8.start = 1'b1; if8.op = op; if8.a = a[7:0]; if8.b = b[7:0]; end
    else begin if32.start = 1'b1; if32.op = op; if32.a = a; if32.b = b; end
    @(posedge clk); #1;
    scyc = cyc;
    // Scramble operands after the sampling edge; they must have no effect.
    if (s) begin if8.start = 1'b0; if8.a = 8'($urandom); if8.b = 8'($urandom); if8.op = 2'($urandom); end
    else begin if32.start = 1'b0; if32.a = $urandom; if32.b = $urandom; if32.op = 2'($urandom); end
    lat = 0; bcnt = 0; dz = 1'b0; ok = 1'b0; hi = '0; lo = '0;
    for (int i = 0; i < 60; i++) begin
      lat++;
      if (rd_busy(s)) bcnt++;
      if (rd_done(s)) begin
        hi = rd_hi(s); lo = rd_lo(s); dz = rd_dz(s); ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    idle_after = !rd_busy(s) && !rd_done(s) && !rd_dz(s);
  endtask

  task automatic test_reset;
    checks++; if (if32.busy !== 1'b0) begin failures++; $display("FAIL reset_busy32 got=%b exp=0", if32.busy); end
    checks++; if (if32.done !== 1'b0) begin failures++; $display("FAIL reset_done32 got=%b exp=0", if32.done); end
    checks++; if (if32.div_zero !== 1'b0) begin failures++; $display("FAIL reset_dz32 got=%b exp=0", if32.div_zero); end
    checks++; if ({if32.hi, if32.lo} !== 64'd0) begin failures++; $display("FAIL reset_hilo32 got=%h_%h exp=0", if32.hi, if32.lo); end
    checks++; if ({if8.busy, if8.hi, if8.lo} !== 17'd0) begin failures++; $display("FAIL reset_8 got=%b/%h/%h exp=0", if8.busy, if8.hi, if8.lo); end
  endtask

  // Directed case: operation with known results and latency.
  task automatic check_op(input string name, input bit s, input logic [1:0] op,
                          input logic [31:0] a, b, input logic [31:0] ehi, elo,
                          input bit edz, input int elat, input int ebusy);
    logic [31:0] hi, lo; int lat, bcnt, sc; bit dz, ok, ia;
    do_op(s, op, a, b, hi, lo, lat, dz, bcnt, ok, ia, sc);
    checks++; if (!ok) begin failures++; $display("FAIL %s_timeout done never seen", name); end
    checks++; if (lat != elat) begin failures++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, elat); end
    checks++; if (bcnt != ebusy) begin failures++; $display("FAIL %s_busy got=%0d exp=%0d", name, bcnt, ebusy); end
    checks++; if (hi !== ehi || lo !== elo) begin failures++; $display("FAIL %s_result got=%h_%h exp=%h_%h", name, hi, lo, ehi, elo); end
    checks++; if (dz !== edz) begin failures++; $display("FAIL %s_divzero got=%b exp=%b", name, dz, edz); end
    checks++; if (!ia) begin failures++; $display("FAIL %s_pulse done/busy not cleared after one cycle", name); end
  endtask

  task automatic test_mult;
    check_op("mult_neg3x7", 1'b0, 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34, 34);
    check_op("multu_max", 1'b0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34, 34);
    check_op("mult_m1xm1", 1'b0, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0, 34, 34);
  endtask

  task automatic test_div;
    check_op("div_neg7_2", 1'b0, 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, 34);
    check_op("divu_7_2", 1'b0, 2'b11, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, 34, 34);
    check_op("div_ovf", 1'b0, 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 34, 34);
  endtask

  task automatic test_div_zero;
    check_op("multu_5x6", 1'b0, 2'b01, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, 34, 34);
    check_op("div_by0", 1'b0, 2'b10, 32'd9, 32'd0, 32'd0, 32'd30, 1'b1, 1, 1);
    check_op("divu_after0", 1'b0, 2'b11, 32'd20, 32'd6, 32'd2, 32'd3, 1'b0, 34, 34);
  endtask

  task automatic test_w8;
    check_op("w8_mult_80x80", 1'b1, 2'b00, 32'h80, 32'h80, 32'h40, 32'h00, 1'b0, 10, 10);
    check_op("w8_div_80_ff", 1'b1, 2'b10, 32'h80, 32'hFF, 32'h00, 32'h80, 1'b0, 10, 10);
    check_op("w8_divu_by0", 1'b1, 2'b11, 32'h33, 32'h00, 32'h00, 32'h80, 1'b1, 1, 1);
  endtask

  function automatic logic [31:0] pick(input int w);
    logic [31:0] m;
    m = 32'((64'd1 << w) - 64'd1);
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return m;
      3: return 32'd1 << (w - 1);
      default: return $urandom & m;
    endcase
  endfunction

  task automatic test_random(input bit s, input int n);
    logic [31:0] hi, lo, ehi, elo, phi, plo, a, b; logic [1:0] op;
    int lat, bcnt, sc, w, nlat; bit dz, edz, ok, ia;
    w = s ? 8 : 32;
    phi = rd_hi(s); plo = 32'd0;
    // Known starting point so the reference tracks hi/lo across divide-by-zero.
    do_op(s, 2'b01, 32'd0, 32'd0, hi, lo, lat, dz, bcnt, ok, ia, sc);
    phi = 32'd0;
    for (int i = 0; i < n; i++) begin
      op = 2'($urandom); a = pick(w); b = pick(w);
      model(w, op, a, b, phi, plo, ehi, elo, edz);
      do_op(s, op, a, b, hi, lo, lat, dz, bcnt, ok, ia, sc);
      nlat = edz ? 1 : w + 2;
      checks++;
      if (!ok || hi !== ehi || lo !== elo || dz !== edz || lat != nlat || !ia) begin
        failures++;
        $display("FAIL rand_w%0d op=%0d a=%h b=%h got=%h_%h dz=%b lat=%0d exp=%h_%h dz=%b lat=%0d",
                 w, op, a, b, hi, lo, dz, lat, ehi, elo, edz, nlat);
      end
      phi = ehi; plo = elo;
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] hi, lo; int lat, bcnt, sc1, sc2; bit dz, ok, ia;
    do_op(1'b0, 2'b01, 32'd11, 32'd13, hi, lo, lat, dz, bcnt, ok, ia, sc1);
    do_op(1'b0, 2'b11, 32'd100, 32'd9, hi, lo, lat, dz, bcnt, ok, ia, sc2);
    checks++; if (sc2 - sc1 != 35) begin failures++; $display("FAIL b2b_period got=%0d exp=35", sc2 - sc1); end
    checks++; if (hi !== 32'd1 || lo !== 32'd11) begin failures++; $display("FAIL b2b_result got=%h_%h exp=1_b", hi, lo); end
  endtask

  task automatic test_ignore_start;
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    if32.start = 1'b1; if32.op = 2'b11; if32.a = 32'd100; if32.b = 32'd7;
    @(posedge clk); #1; if32.start = 1'b0;
    repeat (5) @(posedge clk);
    #1; if32.start = 1'b1; if32.op = 2'b00; if32.a = $urandom; if32.b = $urandom;
    @(posedge clk); #1; if32.start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (if32.done) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL ign_timeout done never seen"); end
    checks++; if (if32.hi !== 32'd2 || if32.lo !== 32'd14) begin failures++; $display("FAIL ign_result got=%h_%h exp=2_e", if32.hi, if32.lo); end
    // Re-pulse during DONE: must not start a new op.
    if32.start = 1'b1; if32.op = 2'b01; if32.a = 32'd3; if32.b = 32'd3;
    @(posedge clk); #1; if32.start = 1'b0;
    checks++; if (if32.busy !== 1'b0) begin failures++; $display("FAIL ign_done_start busy got=%b exp=0", if32.busy); end
    @(posedge clk); #1;
    checks++; if (if32.busy !== 1'b0 || if32.hi !== 32'd2 || if32.lo !== 32'd14) begin
      failures++; $display("FAIL ign_hold busy=%b got=%h_%h exp=0 2_e", if32.busy, if32.hi, if32.lo); end
  endtask

  task automatic test_reset_mid;
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    if32.start = 1'b1; if32.op = 2'b11; if32.a = 32'd1000; if32.b = 32'd3;
    @(posedge clk); #1; if32.start = 1'b0;
    repeat (10) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    checks++; if (if32.busy !== 1'b0 || if32.done !== 1'b0) begin failures++; $display("FAIL rst_mid_state busy=%b done=%b exp=0", if32.busy, if32.done); end
    checks++; if (if32.hi !== 32'd0 || if32.lo !== 32'd0) begin failures++; $display("FAIL rst_mid_hilo got=%h_%h exp=0", if32.hi, if32.lo); end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (if32.done || if32.busy) seen = 1'b1;
    end
    checks++; if (seen) begin failures++; $display("FAIL rst_mid_ghost activity after reset got=1 exp=0"); end
    // Reset and start together: reset wins.
    @(negedge clk);
    reset = 1'b1; if32.start = 1'b1; if32.op = 2'b01; if32.a = 32'd2; if32.b = 32'd2;
    @(posedge clk); #1; reset = 1'b0; if32.start = 1'b0;
    checks++; if (if32.busy !== 1'b0) begin failures++; $display("FAIL rst_start busy got=%b exp=0", if32.busy); end
    @(posedge clk); #1;
    checks++; if (if32.busy !== 1'b0) begin failures++; $display("FAIL rst_start_late busy got=%b exp=0", if32.busy); end
  endtask

  initial begin
    if32.start = 1'b0; if32.op = 2'b00; if32.a = '0; if32.b = '0;
    if8.start  = 1'b0; if8.op  = 2'b00; if8.a  = '0; if8.b  = '0;
    repeat (3) @(posedge clk);
    #1; reset = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_w8();
    test_ignore_start();
    test_back_to_back();
    test_random(1'b0, 40);
    test_random(1'b1, 60);
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
